timer_irq6502: RTL and testbench

- Memory-mapped 16-bit down-counting interval timer on the 6502 data bus.
- Drives the CPU's active-low irq input, so it sits directly upstream of cpu6502.
- The CPU programs it through ordinary loads and stores. The bench's bus mux selects this block's read data when sel is high.
- Gives interrupt-driven test programs a deterministic IRQ source.

---
 rtl/timer_irq6502.sv | 153 +++++++++++++++
 tb/tb_timer_irq6502.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq6502.sv
// Memory-mapped 16-bit down-counting interval timer for the 6502 bus.
// Accesses commit on the falling edge of phi2; raises an active-low irq on underflow.
module timer_irq6502 #(
   parameter logic [15:0] BASE = 16'hD000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        phi2,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   input  logic        rw,
   output logic [7:0]  rdata,
   output logic        sel,
   output logic        irq
);

   localparam logic [2:0] OFF_CTRL   = 3'd0;
   localparam logic [2:0] OFF_RLD_LO = 3'd1;
   localparam logic [2:0] OFF_RLD_HI = 3'd2;
   localparam logic [2:0] OFF_CNT_LO = 3'd3;
   localparam logic [2:0] OFF_CNT_HI = 3'd4;
   localparam logic [2:0] OFF_STATUS = 3'd5;

   localparam logic [7:0] CTRL_MASK = 8'h37;

   logic        phi2_q;
   logic [7:0]  ctrl_q,      ctrl_d;
   logic [15:0] reload_q,    reload_d;
   logic [15:0] count_q,     count_d;
   logic [7:0]  shadow_hi_q, shadow_hi_d;
   logic [7:0]  presc_q,     presc_d;
   logic        flag_q,      flag_d;
   logic        irq_q,       irq_d;

   logic        strobe;
   logic        rd_stb;
   logic        wr_stb;
   logic [2:0]  off;
   logic [7:0]  mask;
   logic        wr_ctrl;
   logic        wr_rld_hi;
   logic        tick;
   logic        expire;

   always_comb begin
      off       = addr[2:0];
      sel       = (addr[15:3] == BASE[15:3]);
      strobe    = phi2_q & ~phi2;
      rd_stb    = strobe & sel & rw;
      wr_stb    = strobe & sel & ~rw;
      wr_ctrl   = wr_stb && (off == OFF_CTRL);
      wr_rld_hi = wr_stb && (off == OFF_RLD_HI);

      case (ctrl_q[5:4])
         2'b00:   mask = 8'h00;
         2'b01:   mask = 8'h07;
         2'b10:   mask = 8'h3F;
         default: mask = 8'hFF;
      endcase

      // Register writes on the same strobe take priority over the countdown.
      tick   = strobe & ctrl_q[0] & ((presc_q & mask) == mask) & ~wr_ctrl & ~wr_rld_hi;
      expire = tick && (count_q == 16'h0000);
   end

   always_comb begin
      ctrl_d      = ctrl_q;
      reload_d    = reload_q;
      count_d     = count_q;
      shadow_hi_d = shadow_hi_q;
      presc_d     = presc_q;
      flag_d      = flag_q;
      irq_d       = ~(flag_q & ctrl_q[1]);

      if (strobe && ctrl_q[0]) begin
         presc_d = presc_q + 8'd1;
      end

      if (tick) begin
         if (!expire) begin
            count_d = count_q - 16'd1;
         end else if (!ctrl_q[2]) begin
            count_d = reload_q;
         end else begin
            ctrl_d[0] = 1'b0;
         end
      end

      if (rd_stb && (off == OFF_CNT_LO)) begin
         shadow_hi_d = count_q[15:8];
      end
      if ((rd_stb && (off == OFF_STATUS)) || (wr_stb && (off == OFF_STATUS) && wdata[7])) begin
         flag_d = 1'b0;
      end
      // A new expiry beats any clear on the same strobe.
      if (expire) begin
         flag_d = 1'b1;
      end

      if (wr_ctrl) begin
         ctrl_d  = wdata & CTRL_MASK;
         presc_d = 8'h00;
      end
      if (wr_stb && (off == OFF_RLD_LO)) begin
         reload_d[7:0] = wdata;
      end
      if (wr_rld_hi) begin
         reload_d[15:8] = wdata;
         count_d        = {wdata, reload_q[7:0]};
         presc_d        = 8'h00;
      end
   end

   always_comb begin
      rdata = 8'hFF;
      if (sel) begin
         case (off)
            OFF_CTRL:   rdata = ctrl_q;
            OFF_RLD_LO: rdata = reload_q[7:0];
            OFF_RLD_HI: rdata = reload_q[15:8];
            OFF_CNT_LO: rdata = count_q[7:0];
            OFF_CNT_HI: rdata = shadow_hi_q;
            OFF_STATUS: rdata = {flag_q, 6'b000000, ctrl_q[0]};
            default:    rdata = 8'hFF;
         endcase
      end
   end

   assign irq = irq_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phi2_q      <= 1'b0;
         ctrl_q      <= 8'h00;
         reload_q    <= 16'h0000;
         count_q     <= 16'h0000;
         shadow_hi_q <= 8'h00;
         presc_q     <= 8'h00;
         flag_q      <= 1'b0;
         irq_q       <= 1'b1;
      end else begin
         phi2_q      <= phi2;
         ctrl_q      <= ctrl_d;
         reload_q    <= reload_d;
         count_q     <= count_d;
         shadow_hi_q <= shadow_hi_d;
         presc_q     <= presc_d;
         flag_q      <= flag_d;
         irq_q       <= irq_d;
      end
   end

endmodule

// File: tb/tb_timer_irq6502.sv
// Directed bench for timer_irq6502: expected values are queued as stimulus is
// issued and compared when the bus or irq line is sampled.
module tb_timer_irq6502;

   logic        clk = 1'b0;
   logic        reset;
   logic        phi2;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic        rw;
   logic [7:0]  rdata;
   logic        sel;
   logic        irq;

   timer_irq6502 #(.BASE(16'hD000)) dut (
      .clk   (clk),
      .reset (reset),
      .phi2  (phi2),
      .addr  (addr),
      .wdata (wdata),
      .rw    (rw),
      .rdata (rdata),
      .sel   (sel),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [7:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic push(input string tag, input logic [7:0] e);
      exp_t item;
      item.tag = tag;
      item.exp = e;
      sb_q.push_back(item);
   endtask

   task automatic pop_check(input logic [7:0] act);
      exp_t item;
      if (sb_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed=%h expected=none", act);
         return;
      end
      item = sb_q.pop_front();
      checks++;
      assert (act === item.exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", item.tag, act, item.exp);
      end
      $display("chk %-14s observed=%h expected=%h", item.tag, act, item.exp);
   endtask

   // One CPU bus cycle: phi2 high for one clk, then low; the strobe is the
   // following rising edge. Read data is sampled just before the strobe.
   task automatic bus(input logic [15:0] a, input logic r, input logic [7:0] wd, input bit chk);
      addr  = a;
      rw    = r;
      wdata = wd;
      phi2  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      phi2 = 1'b0;
      #1;
      if (chk) pop_check(rdata);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      bus(a, 1'b0, d, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) bus(16'h0000, 1'b1, 8'h00, 1'b0);
   endtask

   // Combinational read with phi2 held low, so no strobe and no side effects.
   task automatic peek(input logic [15:0] a);
      addr = a;
      rw   = 1'b1;
      #1;
      pop_check(rdata);
   endtask

   task automatic chk_irq();
      pop_check({7'b0000000, irq});
   endtask

   task automatic chk_sel();
      pop_check({7'b0000000, sel});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0;
      phi2  = 1'b0;
      addr  = 16'h0000;
      wdata = 8'h00;
      rw    = 1'b1;

      // Reset holds through a write strobe
      @(negedge clk);
      bus(16'hD000, 1'b0, 8'hFF, 1'b0);
      push("rst_ctrl", 8'h00);    peek(16'hD000);
      push("rst_irq", 8'h01);     chk_irq();
      push("rst_status", 8'h00);  peek(16'hD005);
      push("rst_off6", 8'hFF);    peek(16'hD006);
      push("rst_sel6", 8'h01);    chk_sel();
      push("rst_out_rd", 8'hFF);  peek(16'h1234);
      push("rst_out_sel", 8'h00); chk_sel();
      @(negedge clk);
      reset = 1'b1;

      // CTRL masking and read-only offsets
      wr(16'hD000, 8'hFE);
      push("ctrl_mask", 8'h36);   peek(16'hD000);
      wr(16'hD000, 8'h00);
      wr(16'hD004, 8'h55);
      push("ro_ignore", 8'h00);   peek(16'hD004);

      // Periodic, /1, reload 3
      wr(16'hD001, 8'h03);
      push("rld_lo", 8'h03);      peek(16'hD001);
      wr(16'hD002, 8'h00);
      wr(16'hD000, 8'h03);
      idle(3);
      push("per_pre", 8'h01);     peek(16'hD005);
      idle(1);
      push("per_flag", 8'h81);    peek(16'hD005);
      push("per_irq_lag", 8'h01); chk_irq();
      @(posedge clk); #1;
      push("per_irq_low", 8'h00); chk_irq();
      @(negedge clk);
      push("per_stat_rd", 8'h81); bus(16'hD005, 1'b1, 8'h00, 1'b1);
      @(posedge clk); #1;
      push("per_irq_rel", 8'h01); chk_irq();
      @(negedge clk);
      idle(2);
      push("per_pre2", 8'h01);    peek(16'hD005);
      idle(1);
      push("per_flag2", 8'h81);   peek(16'hD005);

      // One-shot, reload 2
      wr(16'hD000, 8'h00);
      wr(16'hD005, 8'h80);
      wr(16'hD001, 8'h02);
      wr(16'hD002, 8'h00);
      wr(16'hD000, 8'h07);
      idle(2);
      push("os_pre", 8'h01);      peek(16'hD005);
      idle(1);
      push("os_flag", 8'h80);     peek(16'hD005);
      push("os_cnt", 8'h00);      peek(16'hD003);
      wr(16'hD005, 8'h80);
      idle(5);
      push("os_noflag", 8'h00);   peek(16'hD005);
      push("os_cnt_lo", 8'h00);   bus(16'hD003, 1'b1, 8'h00, 1'b1);
      push("os_cnt_hi", 8'h00);   peek(16'hD004);

      // Prescaler /8, reload 1, IRQEN off
      wr(16'hD001, 8'h01);
      wr(16'hD002, 8'h00);
      wr(16'hD000, 8'h11);
      idle(15);
      push("ps_pre", 8'h01);      peek(16'hD005);
      push("ps_irq_pre", 8'h01);  chk_irq();
      idle(1);
      push("ps_flag", 8'h81);     peek(16'hD005);
      @(posedge clk); #1;
      push("ps_irq_post", 8'h01); chk_irq();
      @(negedge clk);

      // Coherent 16-bit read, reload 0100
      wr(16'hD000, 8'h00);
      wr(16'hD005, 8'h80);
      wr(16'hD001, 8'h00);
      wr(16'hD002, 8'h01);
      wr(16'hD000, 8'h01);
      push("coh_lo", 8'h00);      bus(16'hD003, 1'b1, 8'h00, 1'b1);
      idle(2);
      push("coh_hi", 8'h01);      bus(16'hD004, 1'b1, 8'h00, 1'b1);
      push("coh_cnt", 8'hFC);     peek(16'hD003);

      // STATUS read on the expiring strobe
      wr(16'hD000, 8'h00);
      wr(16'hD005, 8'h80);
      wr(16'hD001, 8'h02);
      wr(16'hD002, 8'h00);
      wr(16'hD000, 8'h03);
      idle(3);
      idle(2);
      push("col_rd", 8'h81);      bus(16'hD005, 1'b1, 8'h00, 1'b1);
      push("col_flag", 8'h81);    peek(16'hD005);
      push("col_irq", 8'h00);     chk_irq();
      @(posedge clk); #1;
      push("col_irq2", 8'h00);    chk_irq();
      @(negedge clk);
      idle(1);
      push("col_cnt", 8'h01);     peek(16'hD003);

      // Asynchronous reset mid-count
      reset = 1'b0;
      #1;
      push("arst_irq", 8'h01);    chk_irq();
      push("arst_cnt_lo", 8'h00); peek(16'hD003);
      push("arst_cnt_hi", 8'h00); peek(16'hD004);
      push("arst_ctrl", 8'h00);   peek(16'hD000);
      @(negedge clk);
      reset = 1'b1;
      idle(3);
      push("arst_status", 8'h00); peek(16'hD005);
      push("arst_irq2", 8'h01);   chk_irq();

      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left observed=%0d expected=0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
